// File: rtl/apb_slave_if.sv
// rtl/apb_slave_if.sv - APB bus signals shared by the master and one completer
interface apb_slave_if;
   logic [1:0]  pselx;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic        pready;
   logic [31:0] prdata;
   logic        pslverr;

   modport master (
      output pselx, penable, pwrite, paddr, pwdata,
      input  pready, prdata, pslverr
   );

   modport slave (
      input  pselx, penable, pwrite, paddr, pwdata,
      output pready, prdata, pslverr
   );
endinterface

// File: rtl/apb_slave.sv
// rtl/apb_slave.sv - APB completer with a flop register file, wait states and error decode
module apb_slave #(
   parameter int          SEL_INDEX   = 0,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          DEPTH       = 16,
   parameter int          WAIT_CYCLES = 0
) (
   input  logic       pclk,
   input  logic       prst,
   apb_slave_if.slave bus
);
   localparam int          IW       = $clog2(DEPTH);
   localparam logic [1:0]  SEL_MASK = 2'(1 << SEL_INDEX);
   localparam logic [32:0] LIMIT    = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);
   localparam logic [3:0]  WAIT_LD  = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          wr_q, wr_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          err_q, err_d;
   logic          pready_q, pready_d;
   logic [31:0]   prdata_q, prdata_d;
   logic          pslverr_q, pslverr_d;
   logic [31:0]   mem_q [DEPTH];

   logic          sel;
   logic [IW-1:0] idx_in;
   logic          err_in;
   logic          ld_wr;
   logic          ld_err;
   logic [IW-1:0] ld_idx;
   logic          complete;
   logic          mem_we;

   assign sel    = |(bus.pselx & SEL_MASK);
   assign idx_in = IW'((bus.paddr - BASE_ADDR) >> 2);
   // 33-bit compares keep the upper bound from wrapping when the window ends at 2^32
   assign err_in = (bus.paddr[1:0] != 2'b00)
                || ({1'b0, bus.paddr} < {1'b0, BASE_ADDR})
                || ({1'b0, bus.paddr} >= LIMIT);

   // A zero-wait completion happens on the setup edge, so it must use the live bus values
   assign ld_wr  = (state_q == S_IDLE) ? bus.pwrite : wr_q;
   assign ld_err = (state_q == S_IDLE) ? err_in     : err_q;
   assign ld_idx = (state_q == S_IDLE) ? idx_in     : idx_q;

   assign bus.pready  = pready_q;
   assign bus.prdata  = prdata_q;
   assign bus.pslverr = pslverr_q;

   // Next-state, setup latching, completion loading and write commit
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wr_d      = wr_q;
      idx_d     = idx_q;
      wdata_d   = wdata_q;
      err_d     = err_q;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      prdata_d  = '0;
      complete  = 1'b0;
      mem_we    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (sel && !bus.penable) begin
               wr_d    = bus.pwrite;
               idx_d   = idx_in;
               wdata_d = bus.pwdata;
               err_d   = err_in;
               if (WAIT_CYCLES == 0) begin
                  state_d  = S_READY;
                  complete = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = WAIT_LD;
               end
            end
         end
         S_WAIT: begin
            if (!sel) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d  = S_READY;
                  complete = 1'b1;
               end
            end
         end
         S_READY: begin
            if (sel && bus.penable && wr_q && !err_q) begin
               mem_we = 1'b1;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (complete) begin
         pready_d  = 1'b1;
         pslverr_d = ld_err;
         prdata_d  = (!ld_wr && !ld_err) ? mem_q[ld_idx] : '0;
      end
   end

   // Control state, latched request and registered response
   always_ff @(posedge pclk or negedge prst) begin
      if (!prst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         wr_q      <= 1'b0;
         idx_q     <= '0;
         wdata_q   <= '0;
         err_q     <= 1'b0;
         pready_q  <= 1'b0;
         prdata_q  <= '0;
         pslverr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wr_q      <= wr_d;
         idx_q     <= idx_d;
         wdata_q   <= wdata_d;
         err_q     <= err_d;
         pready_q  <= pready_d;
         prdata_q  <= prdata_d;
         pslverr_q <= pslverr_d;
      end
   end

   // Register file; reset clears every entry so an in-flight write is lost
   always_ff @(posedge pclk or negedge prst) begin
      if (!prst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (mem_we) begin
         mem_q[idx_q] <= wdata_q;
      end
   end
endmodule

// File: tb/tb_apb_slave.sv
// tb/tb_apb_slave.sv - randomized self-checking bench for four apb_slave configurations
module tb_apb_slave;
   logic        pclk;
   logic        prst;
   logic [1:0]  ps [4];
   logic        pen;
   logic        pwr;
   logic [31:0] padr;
   logic [31:0] pwd;

   logic        exp_r [4];
   logic        exp_e [4];
   logic [31:0] exp_d [4];
   logic [31:0] mem_m [4][16];

   int n_pass  = 0;
   int n_total = 0;
   bit chk_en  = 0;

   apb_slave_if b0 ();
   apb_slave_if b1 ();
   apb_slave_if b2 ();
   apb_slave_if b3 ();

   assign b0.pselx = ps[0];
   assign b1.pselx = ps[1];
   assign b2.pselx = ps[2];
   assign b3.pselx = ps[3];
   assign b0.penable = pen;  assign b1.penable = pen;  assign b2.penable = pen;  assign b3.penable = pen;
   assign b0.pwrite  = pwr;  assign b1.pwrite  = pwr;  assign b2.pwrite  = pwr;  assign b3.pwrite  = pwr;
   assign b0.paddr   = padr; assign b1.paddr   = padr; assign b2.paddr   = padr; assign b3.paddr   = padr;
   assign b0.pwdata  = pwd;  assign b1.pwdata  = pwd;  assign b2.pwdata  = pwd;  assign b3.pwdata  = pwd;

   apb_slave #(.SEL_INDEX(0), .BASE_ADDR(32'h0000_0000), .DEPTH(16), .WAIT_CYCLES(0))
      u0 (.pclk(pclk), .prst(prst), .bus(b0));
   apb_slave #(.SEL_INDEX(1), .BASE_ADDR(32'h0000_0000), .DEPTH(16), .WAIT_CYCLES(3))
      u1 (.pclk(pclk), .prst(prst), .bus(b1));
   apb_slave #(.SEL_INDEX(0), .BASE_ADDR(32'h0000_0000), .DEPTH(8), .WAIT_CYCLES(2))
      u2 (.pclk(pclk), .prst(prst), .bus(b2));
   apb_slave #(.SEL_INDEX(1), .BASE_ADDR(32'hFFFF_FFC0), .DEPTH(16), .WAIT_CYCLES(1))
      u3 (.pclk(pclk), .prst(prst), .bus(b3));

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   function automatic int w_of(int k);
      case (k) 0: return 0; 1: return 3; 2: return 2; default: return 1; endcase
   endfunction
   function automatic int s_of(int k);
      case (k) 0: return 0; 1: return 1; 2: return 0; default: return 1; endcase
   endfunction
   function automatic logic [31:0] base_of(int k);
      return (k == 3) ? 32'hFFFF_FFC0 : 32'h0000_0000;
   endfunction
   function automatic int depth_of(int k);
      return (k == 2) ? 8 : 16;
   endfunction

   function automatic bit model_err(int k, logic [31:0] a);
      longint unsigned av = 64'(a);
      longint unsigned bv = 64'(base_of(k));
      return (av % 4 != 0) || (av < bv) || (av >= bv + 64'(4 * depth_of(k)));
   endfunction
   function automatic int model_idx(int k, logic [31:0] a);
      longint unsigned av = 64'(a);
      longint unsigned bv = 64'(base_of(k));
      return int'(((av - bv) / 4) % 64'(depth_of(k)));
   endfunction

   function automatic logic [1:0] sel_vec(int k, bit on);
      logic [1:0] v;
      int s = s_of(k);
      v = 2'b00;
      if (on) begin
         v[s]   = 1'b1;
         v[1-s] = 1'($urandom_range(0, 1));
      end else begin
         v[1-s] = 1'b1;
      end
      return v;
   endfunction

   function automatic logic [31:0] rand_addr(int k);
      logic [31:0] b = base_of(k);
      int d = depth_of(k);
      case ($urandom_range(0, 6))
         0, 1, 2, 3: return b + 32'(4 * $urandom_range(0, d - 1));
         4:          return b + 32'(4 * $urandom_range(0, d - 1)) + 32'($urandom_range(1, 3));
         5:          return b + 32'(4 * d) + 32'(4 * $urandom_range(0, 3));
         default:    return b - 32'(4 * $urandom_range(1, 4));
      endcase
   endfunction

   task automatic clear_exp();
      for (int j = 0; j < 4; j++) begin
         exp_r[j] = 1'b0;
         exp_e[j] = 1'b0;
         exp_d[j] = 32'h0;
      end
   endtask

   task automatic clear_mem();
      for (int j = 0; j < 4; j++)
         for (int i = 0; i < 16; i++)
            mem_m[j][i] = 32'h0;
   endtask

   task automatic get_out(input int k, output logic r, output logic e, output logic [31:0] d);
      case (k)
         0:       begin r = b0.pready; e = b0.pslverr; d = b0.prdata; end
         1:       begin r = b1.pready; e = b1.pslverr; d = b1.prdata; end
         2:       begin r = b2.pready; e = b2.pslverr; d = b2.prdata; end
         default: begin r = b3.pready; e = b3.pslverr; d = b3.prdata; end
      endcase
   endtask

   task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] expv);
      n_total++;
      if (act === expv) n_pass++;
      else $display("FAIL %s inst%0d: got %h expected %h at %0t", name, k, act, expv, $time);
   endtask

   logic        r_c, e_c;
   logic [31:0] d_c;
   // Every cycle, all four completers' outputs against the transaction-level expectation
   always @(negedge pclk) begin
      if (chk_en) begin
         for (int k = 0; k < 4; k++) begin
            get_out(k, r_c, e_c, d_c);
            check("pready", k, 32'(r_c), 32'(exp_r[k]));
            check("pslverr", k, 32'(e_c), 32'(exp_e[k]));
            check("prdata", k, d_c, exp_d[k]);
         end
      end
   end

   task automatic idle(input bit viol);
      int k = int'($urandom_range(0, 3));
      for (int j = 0; j < 4; j++) ps[j] = sel_vec(j, 1'b0);
      pen = 1'b0;
      if (viol) begin
         ps[k] = sel_vec(k, 1'b1);
         pen   = 1'b1;
      end
      padr = $urandom;
      pwd  = $urandom;
      pwr  = 1'($urandom_range(0, 1));
      clear_exp();
      @(posedge pclk); #1;
   endtask

   task automatic xfer(input int k, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                       input int abort_at, output logic [31:0] rd_o, output logic err_o, output int first_o);
      int          w;
      bit          e;
      int          idx;
      int          ncyc;
      bit          ab;
      logic [31:0] rexp;
      logic        r_a, e_a;
      logic [31:0] d_a;
      w    = w_of(k);
      e    = model_err(k, addr);
      idx  = e ? 0 : model_idx(k, addr);
      rexp = (!wr && !e) ? mem_m[k][idx] : 32'h0;
      rd_o = 32'h0; err_o = 1'b0; first_o = -1;
      for (int j = 0; j < 4; j++) ps[j] = sel_vec(j, j == k);
      pen = 1'b0; pwr = wr; padr = addr; pwd = wd;
      clear_exp();
      @(posedge pclk); #1;
      ncyc = (abort_at < 0) ? w + 1 : abort_at + 1;
      for (int c = 0; c < ncyc; c++) begin
         ab    = (abort_at >= 0) && (c == abort_at);
         ps[k] = sel_vec(k, !ab);
         pen   = !ab;
         clear_exp();
         if (c == w) begin
            exp_r[k] = 1'b1;
            exp_e[k] = e;
            exp_d[k] = rexp;
         end
         get_out(k, r_a, e_a, d_a);
         if (r_a === 1'b1 && first_o < 0) begin
            first_o = c; rd_o = d_a; err_o = e_a;
         end
         @(posedge pclk);
         if (c == w && !ab && wr && !e) mem_m[k][idx] = wd;
         #1;
      end
      for (int j = 0; j < 4; j++) ps[j] = sel_vec(j, 1'b0);
      pen = 1'b0;
      clear_exp();
   endtask

   logic [31:0] rd;
   logic        er;
   int          fr;
   logic        r_t, e_t;
   logic [31:0] d_t;

   // Directed scenarios, mid-transfer reset, then randomized traffic
   initial begin
      prst = 1'b0;
      clear_exp();
      clear_mem();
      for (int j = 0; j < 4; j++) ps[j] = 2'b00;
      pen = 1'b0; pwr = 1'b0; padr = 32'h0; pwd = 32'h0;
      for (int i = 0; i < 6; i++) begin
         @(posedge pclk); #1;
         chk_en = 1'b1;
         for (int j = 0; j < 4; j++) ps[j] = 2'($urandom_range(0, 3));
         pen = 1'($urandom_range(0, 1)); pwr = 1'($urandom_range(0, 1));
         padr = $urandom; pwd = $urandom;
      end
      for (int j = 0; j < 4; j++) ps[j] = sel_vec(j, 1'b0);
      pen = 1'b0;
      prst = 1'b1;
      @(posedge pclk); #1;

      xfer(0, 1'b0, 32'h0, 32'h0, -1, rd, er, fr);
      check("reset_read_data", 0, rd, 32'h0);
      check("reset_read_lat", 0, 32'(fr), 32'd0);

      xfer(0, 1'b1, 32'h8, 32'hDEADBEEF, -1, rd, er, fr);
      check("zw_write_lat", 0, 32'(fr), 32'd0);
      check("zw_write_err", 0, 32'(er), 32'd0);
      xfer(0, 1'b0, 32'h8, 32'h0, -1, rd, er, fr);
      check("zw_read_data", 0, rd, 32'hDEADBEEF);
      check("zw_read_lat", 0, 32'(fr), 32'd0);

      xfer(1, 1'b0, 32'h4, 32'h0, -1, rd, er, fr);
      check("wait3_low_cycles", 1, 32'(fr), 32'd3);
      check("wait3_data", 1, rd, 32'h0);

      xfer(0, 1'b1, 32'h40, 32'hAAAA_5555, -1, rd, er, fr);
      check("oob_write_err", 0, 32'(er), 32'd1);
      check("oob_write_lat", 0, 32'(fr), 32'd0);
      xfer(0, 1'b0, 32'h0, 32'h0, -1, rd, er, fr);
      check("oob_no_alias", 0, rd, 32'h0);
      xfer(0, 1'b0, 32'h6, 32'h0, -1, rd, er, fr);
      check("misalign_err", 0, 32'(er), 32'd1);
      check("misalign_data", 0, rd, 32'h0);

      xfer(2, 1'b1, 32'h10, 32'h5555_0001, -1, rd, er, fr);
      xfer(1, 1'b0, 32'h10, 32'h0, -1, rd, er, fr);
      check("unselected_no_write", 1, rd, 32'h0);
      xfer(1, 1'b1, 32'h10, 32'hCAFE_0001, -1, rd, er, fr);
      check("sel1_write_lat", 1, 32'(fr), 32'd3);
      xfer(1, 1'b0, 32'h10, 32'h0, -1, rd, er, fr);
      check("sel1_read_data", 1, rd, 32'hCAFE_0001);

      xfer(2, 1'b1, 32'hC, 32'h0000_1234, 1, rd, er, fr);
      check("abort_no_ready", 2, 32'(fr), 32'hFFFF_FFFF);
      xfer(2, 1'b0, 32'hC, 32'h0, -1, rd, er, fr);
      check("abort_no_write", 2, rd, 32'h0);
      xfer(2, 1'b1, 32'h0, 32'h0000_1111, -1, rd, er, fr);
      xfer(2, 1'b1, 32'h4, 32'h0000_2222, -1, rd, er, fr);
      check("b2b_second_lat", 2, 32'(fr), 32'd2);
      xfer(2, 1'b0, 32'h0, 32'h0, -1, rd, er, fr);
      check("b2b_read0", 2, rd, 32'h0000_1111);
      xfer(2, 1'b0, 32'h4, 32'h0, -1, rd, er, fr);
      check("b2b_read4", 2, rd, 32'h0000_2222);

      xfer(3, 1'b1, 32'hFFFF_FFC0, 32'h0BAD_F00D, 1, rd, er, fr);
      check("ready_abort_lat", 3, 32'(fr), 32'd1);
      xfer(3, 1'b0, 32'hFFFF_FFC0, 32'h0, -1, rd, er, fr);
      check("ready_abort_no_write", 3, rd, 32'h0);
      xfer(3, 1'b1, 32'hFFFF_FFFC, 32'h7777_8888, -1, rd, er, fr);
      check("top_entry_err", 3, 32'(er), 32'd0);
      xfer(3, 1'b1, 32'h0000_0000, 32'h1357_9BDF, -1, rd, er, fr);
      check("wrap_addr_err", 3, 32'(er), 32'd1);
      xfer(3, 1'b0, 32'hFFFF_FFFC, 32'h0, -1, rd, er, fr);
      check("top_entry_data", 3, rd, 32'h7777_8888);

      for (int j = 0; j < 4; j++) ps[j] = sel_vec(j, j == 0);
      pen = 1'b0; pwr = 1'b0; padr = 32'h8;
      clear_exp();
      @(posedge pclk); #1;
      ps[0] = sel_vec(0, 1'b1); pen = 1'b1;
      exp_r[0] = 1'b1; exp_d[0] = mem_m[0][2];
      get_out(0, r_t, e_t, d_t);
      check("pre_rst_data", 0, d_t, 32'hDEADBEEF);
      #1;
      prst = 1'b0;
      clear_exp();
      clear_mem();
      #1;
      get_out(0, r_t, e_t, d_t);
      check("async_rst_pready", 0, 32'(r_t), 32'd0);
      check("async_rst_prdata", 0, d_t, 32'h0);
      @(posedge pclk); #1;
      for (int j = 0; j < 4; j++) ps[j] = sel_vec(j, 1'b0);
      pen = 1'b0;
      prst = 1'b1;
      @(posedge pclk); #1;
      xfer(0, 1'b0, 32'h8, 32'h0, -1, rd, er, fr);
      check("post_rst_cleared", 0, rd, 32'h0);

      for (int t = 0; t < 400; t++) begin
         int          k;
         int          ab;
         bit          wr;
         logic [31:0] a;
         k  = int'($urandom_range(0, 3));
         wr = 1'($urandom_range(0, 1));
         a  = rand_addr(k);
         ab = -1;
         if ($urandom_range(0, 4) == 0) ab = int'($urandom_range(0, w_of(k)));
         xfer(k, wr, a, $urandom, ab, rd, er, fr);
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle(1'($urandom_range(0, 1)));
      end

      idle(1'b0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/apb_slave.md
# apb_slave

Single-slot APB completer that pairs with the existing APB master on the same `pclk` domain. It decodes one bit of the master's 2-bit `pselx` bus and serves a word-addressed register file of `DEPTH` 32-bit entries. It inserts a programmable number of wait states and flags misaligned or out-of-range accesses on `pslverr`. Two instances (`SEL_INDEX` 0 and 1) sit behind the master to form the complete bus.

## Interface
- `SEL_INDEX`, 0: bit of `pselx` that selects this slave (0 or 1).
- `BASE_ADDR`, 32'h0000_0000: byte address of entry 0. Must be aligned to 4*`DEPTH`.
- `DEPTH`, 16: number of 32-bit entries (power of two, 2..256).
- `WAIT_CYCLES`, 0: number of `penable` cycles with `pready`=0 before completion (0..15).

Ports:
- `pclk`  in  1  bus clock; all state changes on the rising edge.
- `prst`  in  1  asynchronous, active-low reset.
- `pselx`  in  2  slave selects from the master; this slave responds to `pselx[SEL_INDEX]`.
- `penable`  in  1  access-phase indicator.
- `pwrite`  in  1  1 = write, 0 = read.
- `paddr`  in  32  byte address.
- `pwdata`  in  32  write data.
- `pready`  out  1  transfer completion (registered).
- `prdata`  out  32  read data (registered).
- `pslverr`  out  1  error response, valid only while `pready`=1 (registered).

## Operation
- `sel` = `pselx[SEL_INDEX]`. `idx` = (`paddr`-`BASE_ADDR`)>>2, truncated to log2(`DEPTH`) bits.
- `err` = (`paddr[1:0]`!=0) OR (`paddr`<`BASE_ADDR`) OR (`paddr`>=`BASE_ADDR`+4*`DEPTH`). Use a 33-bit compare so the upper bound does not wrap at 2^32.
- FSM states: IDLE, WAIT, READY. Wait counter `cnt` is 4 bits.
- IDLE:
  - On `sel`=1 and `penable`=0 (setup phase): latch `pwrite`, `idx`, `pwdata` and `err`.
  - If `WAIT_CYCLES`=0: go to READY, set `pready`<=1, set `pslverr`<=`err`, and set `prdata`<=(read & !err) ? mem[idx] : 0.
  - Otherwise: go to WAIT with `cnt`<=`WAIT_CYCLES`.
  - `sel`=1 with `penable`=1 while in IDLE is a protocol violation: ignore it and stay in IDLE.
- WAIT:
  - If `sel`=0: abort to IDLE, no write, outputs stay 0.
  - Else decrement `cnt`. When `cnt`=1, go to READY and load `pready`, `pslverr` and `prdata` exactly as in the IDLE zero-wait case.
- READY (`pready`=1):
  - On `sel`&`penable`: if the latched op is a write and !`err`, commit mem[idx]<=latched `pwdata`.
  - Always: `pready`<=0, `pslverr`<=0, `prdata`<=0, go to IDLE.
  - If `sel`=0 in READY: treat as abort, no write, go to IDLE.
- Erroneous writes never modify memory. Erroneous reads return 0.
- Reads use memory contents as of the edge on which `pready` is loaded.

## Timing
- Reset (`prst`=0, asynchronous): state=IDLE, `cnt`=0, `pready`=0, `prdata`=0, `pslverr`=0, all mem entries=0. Memory is built from flops.
- Reset asserted mid-transfer: the transfer is discarded immediately, with no partial write.
- Setup sampled at edge E1. Data-phase outputs become visible after E1+`WAIT_CYCLES`.
- Transfer completes at edge E2+`WAIT_CYCLES`, where E2 = E1+1.
- A write is visible to a read whose `pready` is loaded on any edge after its commit edge.
- Back-to-back: a new setup phase sampled on the edge right after completion is accepted, with no idle cycle required.
- `pready`, `pslverr` and `prdata` are 0 in every cycle outside READY.

## Test plan
- Reset: hold `prst`=0 with random inputs -> `pready`=0, `prdata`=0, `pslverr`=0. Release `prst`, then read addr 0x0 -> 0.
- Zero-wait write/read, `WAIT_CYCLES`=0, `SEL_INDEX`=0: write 0xDEADBEEF to 0x8 -> `pready` high in the first `penable` cycle, `pslverr`=0. Read 0x8 -> `prdata`=0xDEADBEEF in the first `penable` cycle.
- Wait states, `WAIT_CYCLES`=3: read 0x4 -> `pready` low for 3 `penable` cycles and high in the 4th. Total transfer length is 5 cycles including setup.
- Errors, `DEPTH`=16: write to 0x40 -> `pslverr`=1 with `pready`; a later read of 0x0 is unchanged. Read 0x6 -> `pslverr`=1, `prdata`=0.
- Select decode with `SEL_INDEX`=1: transfer with `pselx`=2'b01 -> no response and no write. Same transfer with `pselx`=2'b10 -> normal completion.
- Abort and back-to-back:
  - `WAIT_CYCLES`=2, write 0x1234 to 0xC, drop `pselx` during WAIT -> mem[3] unchanged and FSM back in IDLE.
  - Then two back-to-back writes to 0x0 and 0x4 with no gap -> both complete and read back correctly.
